// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory sequencer: funct3 encodings,
// FSM states, default array size and the load extension/decoding helpers.
package mem_pkg;

    localparam int MEM_BYTES_DEF = 1024;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Sign or zero extend the little-endian assembled load word.
    function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [31:0] raw);
        logic [31:0] res;
        case (funct3)
            F3_B:    res = {{24{raw[7]}}, raw[7:0]};
            F3_H:    res = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   res = {24'h0, raw[7:0]};
            F3_HU:   res = {16'h0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Value of the byte counter on the final access cycle (N-1).
    function automatic logic [1:0] last_cnt(input logic [2:0] funct3);
        logic [1:0] res;
        case (funct3)
            F3_H, F3_HU: res = 2'd1;
            F3_W:        res = 2'd3;
            default:     res = 2'd0;
        endcase
        return res;
    endfunction

    // Illegal funct3 for the direction, or an address not aligned to the size.
    function automatic logic req_error(input logic write, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic res;
        case (funct3)
            F3_B:        res = 1'b0;
            F3_BU:       res = write;
            F3_H:        res = addr_lo[0];
            F3_HU:       res = write | addr_lo[0];
            F3_W:        res = (addr_lo != 2'b00);
            default:     res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/byte_mem_sequencer.sv
// Serialises one RISC-V load/store into 1/2/4 little-endian byte accesses on a
// byte-wide array and returns an extended load word with an error flag.
module byte_mem_sequencer
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out
);

    localparam int AW = $clog2(MEM_BYTES);

    state_t         state_q, state_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           write_q, write_d;
    logic [2:0]     f3_q, f3_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    raw_q, raw_d;
    logic           err_q, err_d;

    logic [AW-1:0]  idx;
    logic [4:0]     lane;
    logic           unused_addr_bits;

    // Upper address bits fall outside the array and are deliberately dropped.
    assign unused_addr_bits = ^req_addr[31:AW];

    assign idx  = addr_q + AW'(cnt_q);
    assign lane = {cnt_q, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            write_q <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            raw_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            raw_q   <= raw_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        write_d          = write_q;
        f3_d             = f3_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        raw_d            = raw_q;
        err_d            = err_q;
        req_ready        = 1'b0;
        rsp_valid        = 1'b0;
        rsp_rdata        = 32'h0;
        rsp_error        = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = 32'h0;
        mem_data_in      = 8'h0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d = req_write;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    raw_d   = 32'h0;
                    cnt_d   = 2'd0;
                    err_d   = req_error(req_write, req_funct3, req_addr[1:0]);
                    state_d = err_d ? RESP : ACCESS;
                end
            end

            ACCESS: begin
                mem_address = {{(30-AW){1'b0}}, idx, 2'b00};
                if (write_q) begin
                    mem_write_enable = 1'b1;
                    mem_data_in      = wdata_q[lane +: 8];
                end else begin
                    raw_d[lane +: 8] = mem_data_out;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == last_cnt(f3_q)) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                rsp_valid = 1'b1;
                rsp_error = err_q;
                rsp_rdata = (err_q || write_q) ? 32'h0 : load_extend(f3_q, raw_q);
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_byte_mem_sequencer.sv
// Directed bench for byte_mem_sequencer with a behavioural byte array.
module tb_byte_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;

    logic [7:0]  mem [1024];
    int          we_cnt = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;

    always #5 clk = ~clk;

    byte_mem_sequencer #(.MEM_BYTES(1024)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out)
    );

    assign mem_data_out = mem[mem_address[11:2]];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            mem[mem_address[11:2]] <= mem_data_in;
            we_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    // Issue one request; returns the response fields and the cycle count from
    // the acceptance edge to the first cycle rsp_valid is seen.
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit take,
                          output logic err, output logic [31:0] rdata, output int lat,
                          output logic [31:0] a0, output logic we0, output logic [7:0] d0);
        int w;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) check("req_ready_wait", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        a0  = mem_address;
        we0 = mem_write_enable;
        d0  = mem_data_in;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        err   = rsp_error;
        rdata = rsp_rdata;
        if (take) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    vec_t        vecs[16];
    logic        g_err;
    logic [31:0] g_rdata;
    int          g_lat;
    logic [31:0] g_a0;
    logic        g_we0;
    logic [7:0]  g_d0;
    int          we_before;
    logic        saw_valid;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        rsp_ready  = 1'b0;

        //            wr    f3    addr          wdata          err   rdata          lat
        vecs[0]  = '{1'b1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000, 5};
        vecs[1]  = '{1'b0, 3'd2, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF, 5};
        vecs[2]  = '{1'b1, 3'd0, 32'h0000_0021, 32'h0000_0080, 1'b0, 32'h0000_0000, 2};
        vecs[3]  = '{1'b1, 3'd0, 32'h0000_0020, 32'h0000_0034, 1'b0, 32'h0000_0000, 2};
        vecs[4]  = '{1'b0, 3'd0, 32'h0000_0021, 32'h0,        1'b0, 32'hFFFFFF80, 2};
        vecs[5]  = '{1'b0, 3'd4, 32'h0000_0021, 32'h0,        1'b0, 32'h00000080, 2};
        vecs[6]  = '{1'b0, 3'd1, 32'h0000_0020, 32'h0,        1'b0, 32'hFFFF8034, 3};
        vecs[7]  = '{1'b0, 3'd5, 32'h0000_0020, 32'h0,        1'b0, 32'h00008034, 3};
        vecs[8]  = '{1'b0, 3'd2, 32'h0000_0013, 32'h0,        1'b1, 32'h00000000, 1};
        vecs[9]  = '{1'b1, 3'd1, 32'h0000_0005, 32'h0000_1234, 1'b1, 32'h00000000, 1};
        vecs[10] = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,        1'b1, 32'h00000000, 1};
        vecs[11] = '{1'b1, 3'd4, 32'h0000_0008, 32'h0000_0077, 1'b1, 32'h00000000, 1};
        vecs[12] = '{1'b0, 3'd1, 32'h0000_0011, 32'h0,        1'b1, 32'h00000000, 1};
        vecs[13] = '{1'b0, 3'd0, 32'h0000_0013, 32'h0,        1'b0, 32'hFFFFFFDE, 2};
        vecs[14] = '{1'b0, 3'd1, 32'h8000_0012, 32'h0,        1'b0, 32'hFFFFDEAD, 3};
        vecs[15] = '{1'b1, 3'd1, 32'h0000_0102, 32'hCAFE_5A6B, 1'b0, 32'h00000000, 3};

        // Reset values
        #12;
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
        check("rst_mem_we", {31'h0, mem_write_enable}, 32'h0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_mem_din", {24'h0, mem_data_in}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            we_before = we_cnt;
            do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b1,
                   g_err, g_rdata, g_lat, g_a0, g_we0, g_d0);
            check($sformatf("v%0d_err", i), {31'h0, g_err}, {31'h0, vecs[i].err});
            check($sformatf("v%0d_rdata", i), g_rdata, vecs[i].rdata);
            check($sformatf("v%0d_lat", i), g_lat, vecs[i].lat);
            check($sformatf("v%0d_we_cycles", i), we_cnt - we_before,
                  (vecs[i].wr && !vecs[i].err) ? vecs[i].lat - 1 : 0);
        end

        check("sw_byte10", {24'h0, mem[16'h10]}, 32'hEF);
        check("sw_byte11", {24'h0, mem[16'h11]}, 32'hBE);
        check("sw_byte12", {24'h0, mem[16'h12]}, 32'hAD);
        check("sw_byte13", {24'h0, mem[16'h13]}, 32'hDE);
        check("sh_byte102", {24'h0, mem[16'h102]}, 32'h6B);
        check("sh_byte103", {24'h0, mem[16'h103]}, 32'h5A);
        check("sh_byte104", {24'h0, mem[16'h104]}, 32'h00);
        check("err_sh_no_write", {24'h0, mem[5]}, 32'h00);

        // Address truncation: bits above the array index are ignored
        do_req(1'b1, 3'd0, 32'h0000_0405, 32'h0000_00AA, 1'b1,
               g_err, g_rdata, g_lat, g_a0, g_we0, g_d0);
        check("trunc_mem_addr", g_a0, 32'h0000_0014);
        check("trunc_we", {31'h0, g_we0}, 32'h1);
        check("trunc_din", {24'h0, g_d0}, 32'hAA);
        check("trunc_byte5", {24'h0, mem[5]}, 32'hAA);

        // Back-pressure: response held, new request ignored until taken
        do_req(1'b0, 3'd2, 32'h0000_0010, 32'h0, 1'b0,
               g_err, g_rdata, g_lat, g_a0, g_we0, g_d0);
        check("bp_lat", g_lat, 5);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd0;
        req_addr   = 32'h0000_0030;
        req_wdata  = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_valid_%0d", i), {31'h0, rsp_valid}, 32'h1);
            check($sformatf("bp_rdata_%0d", i), rsp_rdata, 32'hDEADBEEF);
            check($sformatf("bp_req_ready_%0d", i), {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_idle_valid", {31'h0, rsp_valid}, 32'h0);
        check("bp_ignored_req", {24'h0, mem[16'h30]}, 32'h00);

        // Reset during a store after two bytes have been written
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h0000_0040;
        req_wdata  = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_we_before_rst", {31'h0, mem_write_enable}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_we_after_rst", {31'h0, mem_write_enable}, 32'h0);
        check("mid_req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) saw_valid = 1'b1;
        end
        check("mid_no_rsp", {31'h0, saw_valid}, 32'h0);
        check("mid_byte40", {24'h0, mem[16'h40]}, 32'h44);
        check("mid_byte41", {24'h0, mem[16'h41]}, 32'h33);
        check("mid_byte42", {24'h0, mem[16'h42]}, 32'h00);
        check("mid_byte43", {24'h0, mem[16'h43]}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
